// File: rtl/ic_skolem_pkg.sv
// Shared types for the bvsgt/bvudiv Skolem-witness blocks.
package ic_skolem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MODE_DIVIDEND = 0;
  localparam int MODE_DIVISOR  = 1;

endpackage

// File: rtl/ic_udiv_serial.sv
// Bit-serial restoring unsigned divider, one quotient bit per cycle (MSB first).
// A zero divisor yields an all-ones quotient, matching bvudiv.
module ic_udiv_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quot
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_dvd;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quot;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [W:0]    w_trial;
  logic [W:0]    w_diff;
  logic          w_ge;

  // Partial remainder never exceeds W+1 bits; with divisor 0 every step subtracts nothing.
  assign w_trial = {r_rem, r_dvd[W-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_dvd  <= i_dividend;
        r_dvs  <= i_divisor;
        r_rem  <= '0;
        r_quot <= '0;
        r_cnt  <= CW'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_dvd  <= {r_dvd[W-2:0], 1'b0};
        r_rem  <= w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
        r_quot <= {r_quot[W-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/ic_bvsgt_bvudiv_skolem_seq.sv
// Sequential Skolem-witness generator for "exists x : (x udiv s) >s t" (MODE 0)
// or "exists x : (s udiv x) >s t" (MODE 1), as a valid/ready stage.
//   state | meaning
//   IDLE  | ready for a request
//   DIV   | serial divider running on the chosen candidate
//   CMP   | quotient final, register signed compare
//   DONE  | result valid, waiting for out_ready
module ic_bvsgt_bvudiv_skolem_seq
  import ic_skolem_pkg::*;
#(
  parameter int W    = 4,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] t_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] q_out,
  output logic         ic_ok
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_t;
  logic [W-1:0] r_x;
  logic [W-1:0] r_x_out;
  logic [W-1:0] r_q_out;
  logic         r_ic_ok;

  logic [W-1:0] w_x_cand;
  logic [W-1:0] w_dividend;
  logic [W-1:0] w_divisor;
  logic         w_accept;
  logic         w_div_busy;
  logic         w_div_done;
  logic [W-1:0] w_div_quot;

  // Candidates maximise the reachable quotient, so one division decides existence.
  always_comb begin
    w_x_cand = '0;
    if (MODE == MODE_DIVIDEND) begin
      if (s_in == '0)          w_x_cand = '0;
      else if (s_in == W'(1))  w_x_cand = {1'b0, {(W-1){1'b1}}};
      else                     w_x_cand = '1;
    end else begin
      w_x_cand = s_in[W-1] ? W'(2) : W'(1);
    end
  end

  assign w_dividend = (MODE == MODE_DIVIDEND) ? w_x_cand : s_in;
  assign w_divisor  = (MODE == MODE_DIVIDEND) ? s_in : w_x_cand;
  assign w_accept   = in_valid && (r_state == IDLE);

  ic_udiv_serial #(.W(W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept && !w_div_busy),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_state_nxt = DIV;
      DIV:     if (w_div_done) w_state_nxt = CMP;
      CMP:                     w_state_nxt = DONE;
      DONE:    if (out_ready)  w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t     <= '0;
      r_x     <= '0;
      r_x_out <= '0;
      r_q_out <= '0;
      r_ic_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_t <= t_in;
        r_x <= w_x_cand;
      end
      if (r_state == CMP) begin
        r_x_out <= r_x;
        r_q_out <= w_div_quot;
        r_ic_ok <= ($signed(w_div_quot) > $signed(r_t));
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign x_out     = r_x_out;
  assign q_out     = r_q_out;
  assign ic_ok     = r_ic_ok;

endmodule
